// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_arbiter
// Purpose  : Shares a bank of NUM_FF JK flip-flops between NUM_REQ requesters.
//            A round-robin arbiter accepts one request at a time. The accepted
//            request drives J/K of its target flop for exactly one clock, and
//            all other flops see J/K = 00 during that clock. The new value of
//            the flop is then reported on a one-cycle completion pulse.
// Ports    : clk          rising-edge clock
//            rst_n        synchronous, active-low reset
//            i_req_valid  [NUM_REQ]        request pending per requester
//            i_req_idx    [NUM_REQ*IDX_W]  target flop index per requester
//            i_req_op     [NUM_REQ*2]      {j,k}: 00 hold 01 reset 10 set 11 toggle
//            o_req_ready  [NUM_REQ]        one-hot (or zero) accept strobe
//            o_busy                        operation in flight
//            o_done_valid                  one-cycle completion pulse
//            o_done_id    [clog2(NUM_REQ)] owner of the completion
//            o_done_q                      post-update value of the target flop
//            o_done_err                    index out of range, op ignored
//            o_q          [NUM_FF]         live flop bank contents
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int NUM_FF  = 8,
  parameter int IDX_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]   i_req_idx,
  input  logic [NUM_REQ*2-1:0]       i_req_op,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_busy,
  output logic                       o_done_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_done_id,
  output logic                       o_done_q,
  output logic                       o_done_err,
  output logic [NUM_FF-1:0]          o_q
);

  localparam int c_ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [c_ID_W-1:0]   r_rr_ptr;
  logic [c_ID_W-1:0]   r_id;
  logic [IDX_W-1:0]    r_idx;
  logic [1:0]          r_op;
  logic [NUM_FF-1:0]   r_q;
  logic [NUM_FF-1:0]   w_q_nxt;
  logic [NUM_FF-1:0]   w_j;
  logic [NUM_FF-1:0]   w_k;

  logic                w_found;
  logic [c_ID_W-1:0]   w_win;
  logic [NUM_REQ-1:0]  w_ready;
  logic                w_hs;
  logic [IDX_W-1:0]    w_sel_idx;
  logic [1:0]          w_sel_op;
  logic                w_idx_ok;
  logic                w_sel_q;

  // (base + off) mod NUM_REQ, with off < NUM_REQ so one subtraction suffices.
  function automatic logic [c_ID_W-1:0] rr_index(input logic [c_ID_W-1:0] base,
                                                 input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return c_ID_W'(sum);
  endfunction

  // --------------------------------------------------------------------------
  // Round-robin winner: first valid requester scanning from r_rr_ptr upward.
  // --------------------------------------------------------------------------
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req_valid[rr_index(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = rr_index(r_rr_ptr, k);
      end
    end
  end

  // Ready is suppressed combinationally while reset is asserted so no
  // requester believes it was accepted during a reset cycle.
  always_comb begin
    w_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_found) begin
      w_ready[w_win] = 1'b1;
    end
  end

  assign w_hs = |(i_req_valid & w_ready);

  // Select the winner's index and op with constant slices only.
  always_comb begin
    w_sel_idx = '0;
    w_sel_op  = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (w_win == c_ID_W'(r)) begin
        w_sel_idx = i_req_idx[r*IDX_W +: IDX_W];
        w_sel_op  = i_req_op[r*2 +: 2];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: IDLE -> ISSUE -> DONE -> IDLE
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch and round-robin pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_op     <= '0;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_hs) begin
        r_idx <= w_sel_idx;
        r_op  <= w_sel_op;
        r_id  <= w_win;
      end
      // Pointer moves past the requester just served, so the winner has
      // lowest priority next round.
      if (r_state == S_DONE) begin
        r_rr_ptr <= (r_id == c_ID_W'(NUM_REQ - 1)) ? '0 : r_id + c_ID_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // JK flop bank: only the addressed flop sees the latched J/K, and only in
  // ISSUE. An out-of-range index matches no flop, so the bank is untouched.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_FF; i++) begin : g_ff
    logic w_hit;
    assign w_hit = (r_state == S_ISSUE) && (r_idx == IDX_W'(i));
    assign w_j[i] = w_hit & r_op[1];
    assign w_k[i] = w_hit & r_op[0];

    always_comb begin
      w_q_nxt[i] = r_q[i];
      case ({w_j[i], w_k[i]})
        2'b01:   w_q_nxt[i] = 1'b0;
        2'b10:   w_q_nxt[i] = 1'b1;
        2'b11:   w_q_nxt[i] = ~r_q[i];
        default: w_q_nxt[i] = r_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Completion reporting
  // --------------------------------------------------------------------------
  // Extra bit so the compare is correct even when NUM_FF == 2**IDX_W.
  assign w_idx_ok = ({1'b0, r_idx} < (IDX_W + 1)'(NUM_FF));

  always_comb begin
    w_sel_q = 1'b0;
    for (int i = 0; i < NUM_FF; i++) begin
      if (r_idx == IDX_W'(i)) w_sel_q = r_q[i];
    end
  end

  assign o_req_ready  = w_ready;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done_valid = (r_state == S_DONE);
  assign o_done_id    = (r_state == S_DONE) ? r_id : '0;
  assign o_done_q     = (r_state == S_DONE) && w_idx_ok && w_sel_q;
  assign o_done_err   = (r_state == S_DONE) && !w_idx_ok;
  assign o_q          = r_q;

endmodule
`default_nettype wire
